// File: rtl/s2_hazard_ctrl_if.sv
// S1-to-controller bundle for the S2 hazard controller: S1 instruction operands,
// pipeline kill/freeze requests, and the resulting stall/bubble/freeze controls.
interface s2_hazard_ctrl_if;
    logic [4:0]  S1_ReadSel1;
    logic [4:0]  S1_ReadSel2;
    logic        S1_Uses1;
    logic        S1_Uses2;
    logic [4:0]  S1_WriteSelect;
    logic        S1_WriteEnable;
    logic        S1_valid;
    logic        flush;
    logic        mem_wait;

    logic        stall;
    logic        bubble;
    logic        freeze;
    logic        S2_WriteEnable_gated;
    logic [1:0]  ctrl_state;
    logic [15:0] stall_count;

    // Pipeline side: presents the S1 instruction, consumes the hazard controls.
    modport master (
        output S1_ReadSel1, S1_ReadSel2, S1_Uses1, S1_Uses2,
               S1_WriteSelect, S1_WriteEnable, S1_valid, flush, mem_wait,
        input  stall, bubble, freeze, S2_WriteEnable_gated, ctrl_state, stall_count
    );

    // Controller side.
    modport slave (
        input  S1_ReadSel1, S1_ReadSel2, S1_Uses1, S1_Uses2,
               S1_WriteSelect, S1_WriteEnable, S1_valid, flush, mem_wait,
        output stall, bubble, freeze, S2_WriteEnable_gated, ctrl_state, stall_count
    );
endinterface

// File: rtl/s2_hazard_ctrl.sv
// Interlock controller for a 3-stage pipeline without forwarding: tracks S2/S3 writers
// and stalls S1 on RAW hazards. Define HAZARD_STATS_EN to enable the stall_count statistic.
module s2_hazard_ctrl (
    input logic                clk,
    input logic                rst,
    s2_hazard_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        STALL  = 2'b01,
        FREEZE = 2'b10
    } state_t;

    state_t     state;
    logic [4:0] sh2_ws;
    logic       sh2_we;
    logic [4:0] sh3_ws;
    logic       sh3_we;

    logic       match1;
    logic       match2;
    logic       hazard;
    logic       bubble;

    // Register 0 is hardwired, so a pending write to it never blocks a reader.
    function automatic logic reg_match(input logic [4:0] r,
                                       input logic [4:0] s2_ws, input logic s2_we,
                                       input logic [4:0] s3_ws, input logic s3_we);
        return (r != 5'd0) && ((s2_we && (s2_ws == r)) || (s3_we && (s3_ws == r)));
    endfunction

    // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        match1 = reg_match(bus.S1_ReadSel1, sh2_ws, sh2_we, sh3_ws, sh3_we);
        match2 = reg_match(bus.S1_ReadSel2, sh2_ws, sh2_we, sh3_ws, sh3_we);
        hazard = bus.S1_valid & ~bus.flush &
                 ((bus.S1_Uses1 & match1) | (bus.S1_Uses2 & match2));
        bubble = ~bus.mem_wait & (hazard | bus.flush);
    end

    assign bus.freeze               = bus.mem_wait;
    assign bus.stall                = hazard | bus.mem_wait;
    assign bus.bubble               = bubble;
    assign bus.S2_WriteEnable_gated = bus.S1_WriteEnable & ~bubble;
    assign bus.ctrl_state           = state;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sh2_ws <= 5'd0;
            sh2_we <= 1'b0;
            sh3_ws <= 5'd0;
            sh3_we <= 1'b0;
            state  <= RUN;
        end else begin
            // A frozen pipeline keeps its producers in place, so the shadows must hold too.
            if (!bus.mem_wait) begin
                sh3_ws <= sh2_ws;
                sh3_we <= sh2_we;
                sh2_ws <= bus.S1_WriteSelect;
                sh2_we <= bus.S1_WriteEnable & ~bubble & bus.S1_valid;
            end
            if (bus.mem_wait)
                state <= FREEZE;
            else if (hazard)
                state <= STALL;
            else
                state <= RUN;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_count_q;

    always_ff @(posedge clk) begin
        if (!rst)
            stall_count_q <= 16'd0;
        else if ((bus.ctrl_state == STALL) && (stall_count_q != 16'hFFFF))
            stall_count_q <= stall_count_q + 16'd1;
    end

    assign bus.stall_count = stall_count_q;
`else
    assign bus.stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_s2_hazard_ctrl.sv
// Directed bench for s2_hazard_ctrl: RAW stalls from S2/S3, r0, flush, mem_wait freeze,
// mid-stall reset, and (with HAZARD_STATS_EN) stall_count saturation.
module tb_s2_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    localparam logic [1:0] RUN    = 2'b00;
    localparam logic [1:0] STALL  = 2'b01;
    localparam logic [1:0] FREEZE = 2'b10;

`ifdef HAZARD_STATS_EN
    localparam logic [15:0] CNT_AFTER_RAW = 16'd2;
`else
    localparam logic [15:0] CNT_AFTER_RAW = 16'd0;
`endif

    s2_hazard_ctrl_if bus ();

    s2_hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic s, input logic b, input logic f,
                             input logic g, input logic [1:0] st);
        check({tag, ".stall"},  16'(bus.stall), 16'(s));
        check({tag, ".bubble"}, 16'(bus.bubble), 16'(b));
        check({tag, ".freeze"}, 16'(bus.freeze), 16'(f));
        check({tag, ".gated"},  16'(bus.S2_WriteEnable_gated), 16'(g));
        check({tag, ".state"},  16'(bus.ctrl_state), 16'(st));
    endtask

    task automatic set_s1(input logic v, input logic [4:0] r1, input logic u1,
                          input logic [4:0] r2, input logic u2,
                          input logic [4:0] ws, input logic we);
        bus.S1_valid       = v;
        bus.S1_ReadSel1    = r1;
        bus.S1_Uses1       = u1;
        bus.S1_ReadSel2    = r2;
        bus.S1_Uses2       = u2;
        bus.S1_WriteSelect = ws;
        bus.S1_WriteEnable = we;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        rst          = 1'b0;
        bus.flush    = 1'b0;
        bus.mem_wait = 1'b0;
        set_s1(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        repeat (2) next_cycle();
        rst = 1'b1;

        // Reset state
        settle();
        check_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, RUN);
        check("reset.count", bus.stall_count, 16'd0);
        check("reset.sh2_we", 16'(dut.sh2_we), 16'd0);
        check("reset.sh3_we", 16'(dut.sh3_we), 16'd0);
        next_cycle();

        // S2 RAW: producer of r5, then consumer of r5 -> two stall cycles
        set_s1(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
        settle(); check_out("raw2.p", 1'b0, 1'b0, 1'b0, 1'b1, RUN);
        next_cycle();
        set_s1(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1);
        settle(); check_out("raw2.c1", 1'b1, 1'b1, 1'b0, 1'b0, RUN);
        next_cycle();
        settle(); check_out("raw2.c2", 1'b1, 1'b1, 1'b0, 1'b0, STALL);
        next_cycle();
        settle(); check_out("raw2.issue", 1'b0, 1'b0, 1'b0, 1'b1, STALL);
        next_cycle();
        set_s1(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        settle(); check_out("raw2.after", 1'b0, 1'b0, 1'b0, 1'b0, RUN);
        check("raw2.count", bus.stall_count, CNT_AFTER_RAW);
        next_cycle();

        // r0 never hazards; an unused ReadSel2 never hazards
        set_s1(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        settle(); check_out("r0.p", 1'b0, 1'b0, 1'b0, 1'b1, RUN);
        next_cycle();
        set_s1(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1);
        settle(); check_out("r0.c", 1'b0, 1'b0, 1'b0, 1'b1, RUN);
        next_cycle();
        set_s1(1'b1, 5'd9, 1'b0, 5'd9, 1'b0, 5'd10, 1'b0);
        settle(); check_out("unused.c", 1'b0, 1'b0, 1'b0, 1'b0, RUN);
        next_cycle();

        // S3 RAW: producer of r7, one unrelated, consumer via ReadSel2 -> one stall
        set_s1(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
        settle(); check_out("raw3.p", 1'b0, 1'b0, 1'b0, 1'b1, RUN);
        next_cycle();
        set_s1(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b0);
        settle(); check_out("raw3.mid", 1'b0, 1'b0, 1'b0, 1'b0, RUN);
        next_cycle();
        set_s1(1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 5'd12, 1'b1);
        settle(); check_out("raw3.c1", 1'b1, 1'b1, 1'b0, 1'b0, RUN);
        next_cycle();
        settle(); check_out("raw3.issue", 1'b0, 1'b0, 1'b0, 1'b1, STALL);
        next_cycle();
        set_s1(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        settle(); check_out("raw3.after", 1'b0, 1'b0, 1'b0, 1'b0, RUN);
        next_cycle();
        next_cycle();

        // Flush with a simultaneous hazard: bubble without stall, shadow gets we=0
        set_s1(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
        next_cycle();
        set_s1(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1);
        bus.flush = 1'b1;
        settle(); check_out("flush", 1'b0, 1'b1, 1'b0, 1'b0, RUN);
        next_cycle();
        bus.flush = 1'b0;
        set_s1(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        settle(); check_out("flush.after", 1'b0, 1'b0, 1'b0, 1'b0, RUN);
        check("flush.sh2_we", 16'(dut.sh2_we), 16'd0);
        check("flush.sh2_ws", 16'(dut.sh2_ws), 16'd8);
        next_cycle();
        next_cycle();

        // mem_wait for 3 cycles in the middle of a 2-cycle stall
        set_s1(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
        next_cycle();
        set_s1(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1);
        settle(); check_out("mw.c1", 1'b1, 1'b1, 1'b0, 1'b0, RUN);
        next_cycle();
        bus.mem_wait = 1'b1;
        settle(); check_out("mw.w1", 1'b1, 1'b0, 1'b1, 1'b1, STALL);
        next_cycle();
        settle(); check_out("mw.w2", 1'b1, 1'b0, 1'b1, 1'b1, FREEZE);
        check("mw.sh3_we", 16'(dut.sh3_we), 16'd1);
        check("mw.sh3_ws", 16'(dut.sh3_ws), 16'd5);
        check("mw.sh2_we", 16'(dut.sh2_we), 16'd0);
        next_cycle();
        settle(); check_out("mw.w3", 1'b1, 1'b0, 1'b1, 1'b1, FREEZE);
        next_cycle();
        bus.mem_wait = 1'b0;
        settle(); check_out("mw.resume", 1'b1, 1'b1, 1'b0, 1'b0, FREEZE);
        next_cycle();
        settle(); check_out("mw.issue", 1'b0, 1'b0, 1'b0, 1'b1, STALL);
        next_cycle();
        set_s1(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        settle(); check_out("mw.after", 1'b0, 1'b0, 1'b0, 1'b0, RUN);
        next_cycle();
        next_cycle();

        // Reset asserted mid-stall discards the pending hazard
        set_s1(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
        next_cycle();
        set_s1(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1);
        next_cycle();
        rst = 1'b0;
        settle(); check_out("rst.pre", 1'b1, 1'b1, 1'b0, 1'b0, STALL);
        next_cycle();
        rst = 1'b1;
        settle(); check_out("rst.post", 1'b0, 1'b0, 1'b0, 1'b1, RUN);
        check("rst.count", bus.stall_count, 16'd0);
        next_cycle();

`ifdef HAZARD_STATS_EN
        // Saturation of the stall statistic
        set_s1(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        force bus.ctrl_state = STALL;
        repeat (70000) next_cycle();
        release bus.ctrl_state;
        settle();
        check("stats.sat", bus.stall_count, 16'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
